operand_fetch_ctrl: RTL and testbench

Sequencer that fetches one ALU operand per request and drives the `source` and `mem_data` inputs of `alu_in_mux`. It performs zero, one or two memory reads depending on the `data_src_t` addressing mode. Memory reads use a req/ack handshake, and a wait-timeout is applied to each read. The block sits between instruction decode and the ALU-input mux.

---
 rtl/operand_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: issues zero, one or two memory reads per request
// depending on the addressing mode and drives the ALU input mux.
package operand_fetch_pkg;
  typedef enum logic [2:0] {
    SRC_IMMEDIATE = 3'd0,
    SRC_REG       = 3'd1,
    SRC_MEM_ADDR  = 3'd2,
    SRC_INDIRECT  = 3'd3
  } data_src_t;
endpackage

module operand_fetch_ctrl
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  data_src_t        source,
  input  logic [WIDTH-1:0] immediate,
  output logic             ready,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output data_src_t        mux_src,
  output logic [WIDTH-1:0] mem_data,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PTR  = 2'd1,
    RD_DATA = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Memory handshake: a read is open while mem_req=1; each single-cycle
  // mem_ack closes it, and a changed mem_addr with mem_req still high opens
  // the next one. TIMEOUT=0 keeps a read open until it is acked.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mux_src  <= SRC_IMMEDIATE;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (source)
              SRC_IMMEDIATE, SRC_REG: begin
                mux_src  <= source;
                mem_addr <= immediate;
                state    <= DONE;
                ready    <= 1'b0;
                done     <= 1'b1;
              end
              SRC_MEM_ADDR, SRC_INDIRECT: begin
                mux_src  <= source;
                mem_addr <= immediate;
                state    <= (source == SRC_INDIRECT) ? RD_PTR : RD_DATA;
                ready    <= 1'b0;
                mem_req  <= 1'b1;
                wait_cnt <= '0;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        RD_PTR: begin
          if (mem_ack) begin
            mem_addr <= mem_rdata;
            state    <= RD_DATA;
            wait_cnt <= '0;
          end else if (timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RD_DATA: begin
          // An ack arriving on the final wait cycle still completes the read.
          if (mem_ack) begin
            mem_data <= mem_rdata;
            state    <= DONE;
            mem_req  <= 1'b0;
            done     <= 1'b1;
          end else if (timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl: fixed vectors with hand-computed
// cycle-by-cycle expectations, inputs driven and outputs sampled on negedge.
module tb_operand_fetch_ctrl;
  import operand_fetch_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  data_src_t        source;
  logic [WIDTH-1:0] immediate;
  logic             ready;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;
  data_src_t        mux_src;
  logic [WIDTH-1:0] mem_data;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;

  operand_fetch_ctrl #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .source(source),
    .immediate(immediate), .ready(ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mux_src(mux_src), .mem_data(mem_data), .done(done), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a request for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input data_src_t src, input logic [WIDTH-1:0] imm);
    start     = 1'b1;
    source    = src;
    immediate = imm;
    step();
    start     = 1'b0;
  endtask

  logic seen_done;
  logic seen_req;
  data_src_t src_k;

  initial begin
    rst_n = 1'b0; start = 1'b0; source = SRC_IMMEDIATE; immediate = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    // reset state
    check("rst_ready", ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_src", mux_src, SRC_IMMEDIATE);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // IMM 0x5A: done in cycle 1, no memory access
    seen_req = 1'b0;
    issue(SRC_IMMEDIATE, 8'h5A);
    seen_req |= mem_req;
    check("imm_done_c1", done, 1);
    check("imm_ready_c1", ready, 0);
    check("imm_src", mux_src, SRC_IMMEDIATE);
    check("imm_addr", mem_addr, 8'h5A);
    step();
    seen_req |= mem_req;
    check("imm_done_c2", done, 0);
    check("imm_ready_c2", ready, 1);
    check("imm_no_req", seen_req, 0);

    // MEM_ADDR 0x10, ack after 3 waits (ack in cycle 4) with 0xC3
    issue(SRC_MEM_ADDR, 8'h10);
    for (int c = 1; c <= 4; c++) begin
      check("ma_req", mem_req, 1);
      check("ma_addr", mem_addr, 8'h10);
      check("ma_done_early", done, 0);
      mem_ack   = (c == 4);
      mem_rdata = (c == 4) ? 8'hC3 : 8'hEE;
      step();
    end
    mem_ack = 1'b0;
    check("ma_done_c5", done, 1);
    check("ma_data", mem_data, 8'hC3);
    check("ma_req_off", mem_req, 0);
    check("ma_src", mux_src, SRC_MEM_ADDR);
    step();

    // INDIRECT 0x20 -> 0x44 -> 0x99, zero wait
    issue(SRC_INDIRECT, 8'h20);
    check("ind_req_c1", mem_req, 1);
    check("ind_addr_c1", mem_addr, 8'h20);
    mem_ack = 1'b1; mem_rdata = 8'h44;
    step();
    check("ind_req_c2", mem_req, 1);
    check("ind_addr_c2", mem_addr, 8'h44);
    check("ind_done_c2", done, 0);
    mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    check("ind_done_c3", done, 1);
    check("ind_data", mem_data, 8'h99);
    check("ind_req_off", mem_req, 0);
    step();

    // MEM_ADDR with no ack: err in cycle 17, no done, mem_data kept
    seen_done = 1'b0;
    issue(SRC_MEM_ADDR, 8'h30);
    for (int c = 1; c <= 16; c++) begin
      seen_done |= done;
      if (c == 16) begin
        check("to_req_c16", mem_req, 1);
        check("to_err_c16", err, 0);
      end
      step();
    end
    check("to_err_c17", err, 1);
    check("to_req_c17", mem_req, 0);
    check("to_ready_c17", ready, 1);
    check("to_data_kept", mem_data, 8'h99);
    step();
    seen_done |= done;
    check("to_no_done", seen_done, 0);
    check("to_err_c18", err, 0);

    // ack exactly at count 15 (cycle 16) wins
    issue(SRC_MEM_ADDR, 8'h31);
    for (int c = 1; c <= 16; c++) begin
      mem_ack   = (c == 16);
      mem_rdata = 8'h77;
      step();
    end
    mem_ack = 1'b0;
    check("late_done", done, 1);
    check("late_err", err, 0);
    check("late_data", mem_data, 8'h77);
    step();

    // reset during RD_PTR
    issue(SRC_INDIRECT, 8'h50);
    check("rp_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rp_req_async", mem_req, 0);
    check("rp_ready", ready, 1);
    check("rp_addr", mem_addr, 0);
    check("rp_data", mem_data, 0);
    check("rp_src", mux_src, SRC_IMMEDIATE);
    step();
    rst_n = 1'b1;
    step();
    issue(SRC_IMMEDIATE, 8'h11);
    check("rp_imm_done", done, 1);
    check("rp_imm_addr", mem_addr, 8'h11);
    step();

    // start held high, source pattern REG,IMM,IMM,REG,REG,IMM; ack held high
    mem_ack = 1'b1; mem_rdata = 8'hAB;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        if (k % 2 == 1) begin
          src_k = ((k - 1) % 4 == 0) ? SRC_REG : SRC_IMMEDIATE;
          check("b2b_done", done, 1);
          check("b2b_src", mux_src, src_k);
          check("b2b_addr", mem_addr, k - 1);
        end else begin
          check("b2b_idle_done", done, 0);
          check("b2b_idle_ready", ready, 1);
        end
        check("b2b_req", mem_req, 0);
        check("b2b_data", mem_data, 0);
      end
      if (k < 6) begin
        start     = 1'b1;
        source    = (k % 4 == 0 || k % 4 == 3) ? SRC_REG : SRC_IMMEDIATE;
        immediate = WIDTH'(k);
      end else begin
        start = 1'b0;
      end
      step();
    end
    mem_ack = 1'b0;

    // illegal encoding: err only, mux_src unchanged
    issue(data_src_t'(3'd5), 8'hF0);
    check("ill_err", err, 1);
    check("ill_done", done, 0);
    check("ill_ready", ready, 1);
    check("ill_src", mux_src, SRC_REG);
    check("ill_req", mem_req, 0);
    step();
    check("ill_err_c2", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
